// File: rtl/scanner_result_scheduler_pkg.sv
// Shared types for the scanner result path: EAN-13 width, scheduler FSM
// encoding and the {vpixel, code} word written into the result FIFO.
package scanner_pkg;
  localparam int EAN13_WIDTH = 52;
  localparam int VPIXEL_W    = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } schedState_e;

  typedef struct packed {
    logic [VPIXEL_W-1:0]    vpixel;
    logic [EAN13_WIDTH-1:0] code;
  } fifoWord_t;
endpackage

// File: rtl/scanner_result_scheduler_if.sv
// Scanner-decode input and result-FIFO write port of the scheduler.
interface scanner_result_scheduler_if #(
  parameter int CODE_WIDTH   = scanner_pkg::EAN13_WIDTH,
  parameter int VPIXEL_WIDTH = scanner_pkg::VPIXEL_W
);
  logic                               iNewData;
  logic [CODE_WIDTH-1:0]              iDataCode;
  logic [VPIXEL_WIDTH-1:0]            iVpixel;
  logic                               iFifoFull;
  logic                               oFifoWrEn;
  logic [VPIXEL_WIDTH+CODE_WIDTH-1:0] oFifoData;

  modport master (output iNewData, iDataCode, iVpixel, iFifoFull,
                  input  oFifoWrEn, oFifoData);
  modport slave  (input  iNewData, iDataCode, iVpixel, iFifoFull,
                  output oFifoWrEn, oFifoData);
endinterface

// File: rtl/scanner_result_scheduler_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module scanner_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iInc,
  output logic [WIDTH-1:0] oCount
);
  always_ff @(posedge iClk) begin
    if (iRst)                       oCount <= '0;
    else if (iInc && oCount != '1)  oCount <= oCount + WIDTH'(1);
  end
endmodule

// File: rtl/scanner_result_scheduler.sv
// Confirms EAN-13 decodes across nearby lines, reports each code once per
// frame (capped), and buffers one report against FIFO backpressure.
module scanner_result_scheduler
  import scanner_pkg::*;
#(
  parameter int CODE_WIDTH    = EAN13_WIDTH,
  parameter int VPIXEL_WIDTH  = VPIXEL_W,
  parameter int CONFIRM_COUNT = 3,
  parameter int MAX_LINE_GAP  = 4,
  parameter int MAX_PER_FRAME = 4
) (
  input  logic  iClk,
  input  logic  iRst,
  input  logic  iEnable,
  input  logic  iFrameStart,
  scanner_result_scheduler_if.slave bus,
  output logic [15:0] oFrameCount,
  output logic [7:0]  oDropCount,
  output logic        oPending
);
  schedState_e                        state, stateNext, effState;
  logic [CODE_WIDTH-1:0]              candCode, candCodeNext;
  logic [VPIXEL_WIDTH-1:0]            candVpixel, candVpNext;
  logic [VPIXEL_WIDTH-1:0]            lastVpixel, lastVpNext, lineGap;
  logic [3:0]                         matchCnt, matchCntNext, matchInc;
  logic [3:0]                         reportCnt, reportCntNext, effReport;
  logic [VPIXEL_WIDTH+CODE_WIDTH-1:0] holdWord;
  logic process, isMatch, loadCand, emit, wrEn, canLoad;

  // A coincident frame start takes effect before the detection is looked at.
  assign effState  = iFrameStart ? IDLE : state;
  assign effReport = iFrameStart ? 4'd0 : reportCnt;
  assign process   = bus.iNewData & iEnable & (effReport < 4'(MAX_PER_FRAME));
  assign lineGap   = bus.iVpixel - lastVpixel;
  assign isMatch   = (bus.iDataCode == candCode) &&
                     (lineGap <= VPIXEL_WIDTH'(MAX_LINE_GAP));
  assign matchInc  = matchCnt + 4'd1;

  always_comb begin
    stateNext     = effState;
    candCodeNext  = candCode;
    candVpNext    = candVpixel;
    lastVpNext    = lastVpixel;
    matchCntNext  = iFrameStart ? 4'd0 : matchCnt;
    reportCntNext = effReport;
    loadCand      = 1'b0;
    emit          = 1'b0;
    if (!iEnable) stateNext = IDLE;
    if (process) begin
      case (effState)
        CONFIRM: begin
          if (isMatch) begin
            matchCntNext = matchInc;
            lastVpNext   = bus.iVpixel;
            if (matchInc == 4'(CONFIRM_COUNT)) begin
              emit      = 1'b1;
              stateNext = LOCKED;
            end
          end else begin
            loadCand = 1'b1;
          end
        end
        LOCKED:  loadCand = (bus.iDataCode != candCode);
        default: loadCand = 1'b1;
      endcase
      if (loadCand) begin
        candCodeNext = bus.iDataCode;
        candVpNext   = bus.iVpixel;
        lastVpNext   = bus.iVpixel;
        matchCntNext = 4'd1;
        if (CONFIRM_COUNT == 1) begin
          emit      = 1'b1;
          stateNext = LOCKED;
        end else begin
          stateNext = CONFIRM;
        end
      end
      if (emit) reportCntNext = effReport + 4'd1;
    end
  end

  assign wrEn          = oPending & ~bus.iFifoFull;
  assign canLoad       = ~oPending | wrEn;
  assign bus.oFifoWrEn = wrEn;
  assign bus.oFifoData = holdWord;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      candCode    <= '0;
      candVpixel  <= '0;
      lastVpixel  <= '0;
      matchCnt    <= '0;
      reportCnt   <= '0;
      holdWord    <= '0;
      oPending    <= 1'b0;
      oFrameCount <= '0;
    end else begin
      state       <= stateNext;
      candCode    <= candCodeNext;
      candVpixel  <= candVpNext;
      lastVpixel  <= lastVpNext;
      matchCnt    <= matchCntNext;
      reportCnt   <= reportCntNext;
      oFrameCount <= oFrameCount + 16'(iFrameStart);
      if (emit && canLoad) begin
        holdWord <= {candVpNext, candCodeNext};
        oPending <= 1'b1;
      end else if (wrEn) begin
        oPending <= 1'b0;
      end
    end
  end

  scanner_sat_counter #(.WIDTH(8)) dropCounter (
    .iClk  (iClk),
    .iRst  (iRst),
    .iInc  (emit & ~canLoad),
    .oCount(oDropCount)
  );
endmodule

// File: doc/scanner_result_scheduler.md
# scanner_result_scheduler

Sequences EAN-13 decode results from the scanner core into the video-to-system result FIFO. It runs on the 2x video clock between the EAN-13 scanner and the FIFO write port. A result is forwarded only after the same code has been decoded on several nearby lines, each code is reported once per frame, the number of reports per frame is capped, and FIFO backpressure is absorbed in a one-entry holding register with drop accounting.

## Interface
- CODE_WIDTH, 52, decoded EAN-13 code width
- VPIXEL_WIDTH, 10, line-number width
- CONFIRM_COUNT, 3, consecutive matching detections required before a report (1..15)
- MAX_LINE_GAP, 4, maximum line distance between consecutive matching detections
- MAX_PER_FRAME, 4, maximum reports per frame (1..15)

Ports:
- iClk  in  1  video clock
- iRst  in  1  reset, synchronous, active-high
- iEnable  in  1  scheduler enable from the scanner control word
- iFrameStart  in  1  one-cycle pulse on the first cycle of each frame
- iNewData  in  1  one-cycle pulse: scanner produced a decode
- iDataCode  in  CODE_WIDTH  decoded code, valid with iNewData
- iVpixel  in  VPIXEL_WIDTH  line of the decode, valid with iNewData
- iFifoFull  in  1  FIFO full flag
- oFifoWrEn  out  1  FIFO write enable
- oFifoData  out  VPIXEL_WIDTH+CODE_WIDTH  {vpixel, code}
- oFrameCount  out  16  frames seen, wraps
- oDropCount  out  8  reports lost to backpressure, saturates at 255
- oPending  out  1  holding register occupied

## Operation
- FSM states: IDLE (no candidate), CONFIRM (candidate held, matchCnt counting), LOCKED (candidate reported this frame).
- Registers: candCode, candVpixel (first line of the candidate), lastVpixel, matchCnt[3:0], reportCnt[3:0].
- A detection is processed only when iNewData=1, iEnable=1 and reportCnt<MAX_PER_FRAME. Otherwise it is ignored.
- A detection "matches" when iDataCode==candCode and (iVpixel−lastVpixel), unsigned at VPIXEL_WIDTH, is ≤ MAX_LINE_GAP.
- IDLE: load the candidate, matchCnt=1, lastVpixel=iVpixel, go to CONFIRM. If CONFIRM_COUNT==1, emit and go to LOCKED instead.
- CONFIRM, on a match: matchCnt+1 and update lastVpixel. When the count reaches CONFIRM_COUNT, emit and go to LOCKED.
- CONFIRM, on a non-match: reload the candidate with matchCnt=1.
- LOCKED: a detection with the same code is ignored. A different code reloads the candidate and goes to CONFIRM (or emits at once if CONFIRM_COUNT==1).
- Emit:
  - Loads {candVpixel, candCode} into the holding register if it is empty or is being written this cycle.
  - Otherwise oDropCount saturating-increments and the holding register is unchanged.
  - reportCnt increments in both cases.
- iFrameStart:
  - Sets state=IDLE, matchCnt=0, reportCnt=0.
  - oFrameCount+1.
  - The holding register is preserved.
  - If iNewData arrives in the same cycle, the frame start is applied first and the detection is then processed as IDLE in the new frame.
- iEnable=0: forces IDLE. The holding register still drains.
- Write-out: oFifoWrEn = oPending & ~iFifoFull (combinational). oPending clears on a write unless a new emit reloads it in the same cycle.

## Timing
- Reset values: state IDLE; all counters and registers 0; oFifoWrEn=0, oFifoData=0, oPending=0, oFrameCount=0, oDropCount=0.
- Latency: the confirming iNewData at cycle N gives oPending=1 at N+1. oFifoWrEn goes high at N+1 if iFifoFull=0.
- One detection is processed per cycle. Back-to-back iNewData is supported.
- oFifoData is stable while oPending=1 and not written.
- iRst mid-operation: all state returns to reset values on the next edge, including the holding register (its content is lost and not counted as a drop).

## Structure
- Shared package scanner_pkg: EAN13 code width (52), the FSM state encoding (IDLE/CONFIRM/LOCKED), and the FIFO word layout {vpixel, code}.
- One natural sub-module: scanner_sat_counter, a parameterised-width saturating counter, used for oDropCount.
- Everything else is inline.

## Test plan
- Detections of code 0x0123456789ABC on lines 100, 102, 104, FIFO not full -> one write of {100, code} one cycle after the line-104 pulse; no further write for repeats in the same frame.
- Same code on lines 100, 102, then 110 (gap 8) -> no write; the candidate restarts at 110 and a write of {110, code} follows after lines 112 and 114.
- iFifoFull=1 held while two distinct codes confirm -> the first is held (oPending=1), the second is dropped and oDropCount=1; after full is released, exactly one write of the first code.
- Six distinct codes confirmed in one frame, MAX_PER_FRAME=4 -> exactly 4 reports; after iFrameStart, oFrameCount increments and the next confirmed code is written.
- iFrameStart coincident with the third matching detection -> no write; the detection counts as match 1 of the new frame.
- iRst asserted with oPending=1 -> next cycle oPending=0, oFifoWrEn=0, all counters 0.
